// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// UART byte width and the instruction-memory size.
package imem_boot_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int IMEM_BYTES = 65536;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } boot_state_e;

  // The loader keeps the memory port from the moment a load starts until it
  // completes; a failed load keeps it too so fetch never sees a partial image.
  function automatic logic loader_owns_port(boot_state_e s);
    logic owns;
    case (s)
      ST_LEN, ST_LOAD, ST_DRAIN, ST_ERROR: owns = 1'b1;
      default:                             owns = 1'b0;
    endcase
    return owns;
  endfunction

endpackage

// File: rtl/imem_port_mux.sv
// Arbitrates the instruction-memory port between the boot loader and fetch.
module imem_port_mux
  import imem_boot_loader_pkg::*;
(
  input  logic              loader_owns,
  input  logic [31:0]       fetch_pc,
  input  logic [31:0]       loader_addr,
  input  logic              loader_we,
  input  logic [BYTE_W-1:0] loader_wdata,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_wdata
);

  // Address/strobe selection; fetch_pc passes straight through when fetch owns the port
  always_comb begin
    mem_addr  = fetch_pc;
    mem_we    = 1'b0;
    mem_wdata = loader_wdata;
    if (loader_owns) begin
      mem_addr = loader_addr;
      mem_we   = loader_we;
    end else begin
      mem_addr = fetch_pc;
      mem_we   = 1'b0;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Length-prefixed byte-stream loader that fills instruction memory while the
// pipeline is held, with an inter-byte timeout and a bounds check on length.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int MEM_BYTES   = IMEM_BYTES,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  input  logic [31:0]       fetch_pc,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [31:0]       bytes_loaded
);

  localparam logic [31:0] MAX_LEN  = 32'(MEM_BYTES - BASE_ADDR);
  localparam logic [31:0] BASE_A   = 32'(BASE_ADDR);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  boot_state_e       state_r, state_s;
  logic [31:0]       len_r, len_s, len_full_s;
  logic [1:0]        len_cnt_r, len_cnt_s;
  logic [31:0]       rx_cnt_r, rx_cnt_s;
  logic [31:0]       idx_r, idx_s;
  logic [31:0]       tmo_r, tmo_s;
  logic              we_r, we_s;
  logic [BYTE_W-1:0] wdata_r, wdata_s;
  logic              hold_r, hold_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              ready_r, ready_s;
  logic              accept_s;

  assign accept_s   = rx_valid && ready_r;
  assign len_full_s = {rx_data, len_r[31:8]};

  // Next-state and datapath updates for the load FSM
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    len_cnt_s = len_cnt_r;
    rx_cnt_s  = rx_cnt_r;
    tmo_s     = tmo_r;
    we_s      = 1'b0;
    wdata_s   = wdata_r;
    hold_s    = hold_r;
    done_s    = done_r;
    err_s     = err_r;
    // A registered write lands this cycle; advance the write index behind it.
    if (we_r) begin
      idx_s = idx_r + 32'd1;
    end else begin
      idx_s = idx_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_s   = ST_LEN;
          len_s     = 32'd0;
          len_cnt_s = 2'd0;
          rx_cnt_s  = 32'd0;
          idx_s     = 32'd0;
          tmo_s     = 32'd0;
          hold_s    = 1'b1;
          done_s    = 1'b0;
          err_s     = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          tmo_s     = 32'd0;
          len_s     = len_full_s;
          len_cnt_s = len_cnt_r + 2'd1;
          if (len_cnt_r == 2'd3) begin
            if (len_full_s == 32'd0) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
              hold_s  = 1'b0;
            end else if (len_full_s > MAX_LEN) begin
              state_s = ST_ERROR;
              err_s   = 1'b1;
            end else begin
              state_s = ST_LOAD;
            end
          end else begin
            state_s = ST_LEN;
          end
        end else if (tmo_r >= TMO_LAST) begin
          state_s = ST_ERROR;
          err_s   = 1'b1;
        end else begin
          tmo_s = tmo_r + 32'd1;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          tmo_s    = 32'd0;
          we_s     = 1'b1;
          wdata_s  = rx_data;
          rx_cnt_s = rx_cnt_r + 32'd1;
          if (rx_cnt_r == (len_r - 32'd1)) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_LOAD;
          end
        end else if (tmo_r >= TMO_LAST) begin
          state_s = ST_ERROR;
          err_s   = 1'b1;
        end else begin
          tmo_s = tmo_r + 32'd1;
        end
      end
      ST_DRAIN: begin
        state_s = ST_DONE;
        done_s  = 1'b1;
        hold_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    ready_s = (state_s == ST_LEN) || (state_s == ST_LOAD);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      len_r     <= 32'd0;
      len_cnt_r <= 2'd0;
      rx_cnt_r  <= 32'd0;
      idx_r     <= 32'd0;
      tmo_r     <= 32'd0;
      we_r      <= 1'b0;
      wdata_r   <= {BYTE_W{1'b0}};
      hold_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      len_r     <= len_s;
      len_cnt_r <= len_cnt_s;
      rx_cnt_r  <= rx_cnt_s;
      idx_r     <= idx_s;
      tmo_r     <= tmo_s;
      we_r      <= we_s;
      wdata_r   <= wdata_s;
      hold_r    <= hold_s;
      done_r    <= done_s;
      err_r     <= err_s;
      ready_r   <= ready_s;
    end
  end

  imem_port_mux u_port_mux (
    .loader_owns  (loader_owns_port(state_r)),
    .fetch_pc     (fetch_pc),
    .loader_addr  (BASE_A + idx_r),
    .loader_we    (we_r),
    .loader_wdata (wdata_r),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata)
  );

  assign rx_ready     = ready_r;
  assign cpu_hold     = hold_r;
  assign load_done    = done_r;
  assign load_err     = err_r;
  assign bytes_loaded = idx_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (TIMEOUT_CYC shortened to 16).
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] fetch_pc;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [31:0] bytes_loaded;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [7:0] mem_model [0:255];

  imem_boot_loader #(
    .MEM_BYTES   (65536),
    .BASE_ADDR   (0),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .fetch_pc     (fetch_pc),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .bytes_loaded (bytes_loaded)
  );

  always #5 clk = ~clk;

  // Memory model: writes observed mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      if (mem_addr < 32'd256) mem_model[mem_addr[7:0]] = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte at a negedge; it must be taken at the next posedge.
  task automatic put(input logic [7:0] b, input logic payload, input logic [31:0] addr);
    rx_valid = 1'b1;
    rx_data  = b;
    chk("rx_ready_on_offer", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    if (payload) begin
      chk("write_strobe", {31'd0, mem_we}, 32'd1);
      chk("write_addr", mem_addr, addr);
      chk("write_data", {24'd0, mem_wdata}, {24'd0, b});
    end else begin
      chk("no_write_in_len", {31'd0, mem_we}, 32'd0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] p1 [0:7];
    logic [7:0] p5 [0:4];
    p1[0] = 8'h13; p1[1] = 8'h00; p1[2] = 8'h00; p1[3] = 8'h00;
    p1[4] = 8'h93; p1[5] = 8'h00; p1[6] = 8'h10; p1[7] = 8'h00;
    p5[0] = 8'hC1; p5[1] = 8'hC2; p5[2] = 8'hC3; p5[3] = 8'hC4; p5[4] = 8'hC5;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'hEE;

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    fetch_pc = 32'h0000_0100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_bytes_loaded", bytes_loaded, 32'd0);
    chk("rst_mem_addr_fetch", mem_addr, 32'h0000_0100);

    // Load 8 bytes back-to-back
    chk("hold_low_at_start", {31'd0, cpu_hold}, 32'd0);
    pulse_start();
    chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    chk("addr_loader_in_len", mem_addr, 32'd0);
    put(8'h08, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      put(p1[i], 1'b1, 32'(i));
      chk("hold_during_load", {31'd0, cpu_hold}, 32'd1);
    end
    chk("rx_ready_drain", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    chk("done_no_write", {31'd0, mem_we}, 32'd0);
    chk("done_hold", {31'd0, cpu_hold}, 32'd0);
    chk("done_flag", {31'd0, load_done}, 32'd1);
    chk("done_bytes", bytes_loaded, 32'd8);
    chk("done_rx_ready", {31'd0, rx_ready}, 32'd0);
    fetch_pc = 32'd4;
    #1;
    chk("fetch_pc_passthru", mem_addr, 32'd4);
    chk("wr_cnt_load8", 32'(wr_cnt), 32'd8);
    for (int i = 0; i < 8; i++) chk("mem_load8", {24'd0, mem_model[i]}, {24'd0, p1[i]});

    // Zero length
    @(negedge clk);
    pulse_start();
    chk("start_clears_done", {31'd0, load_done}, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    chk("len0_done", {31'd0, load_done}, 32'd1);
    chk("len0_hold", {31'd0, cpu_hold}, 32'd0);
    chk("len0_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("len0_bytes", bytes_loaded, 32'd0);
    chk("len0_wr_cnt", 32'(wr_cnt), 32'd8);

    // Oversize length 65537
    pulse_start();
    put(8'h01, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h01, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    chk("big_err", {31'd0, load_err}, 32'd1);
    chk("big_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("big_hold", {31'd0, cpu_hold}, 32'd1);
    chk("big_done", {31'd0, load_done}, 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk("err_no_writes", 32'(wr_cnt), 32'd8);
    chk("err_hold_kept", {31'd0, cpu_hold}, 32'd1);

    // Timeout after 2 of 4 payload bytes
    pulse_start();
    chk("start_clears_err", {31'd0, load_err}, 32'd0);
    put(8'h04, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'hAA, 1'b1, 32'd0);
    put(8'hBB, 1'b1, 32'd1);
    repeat (10) @(negedge clk);
    chk("tmo_not_yet", {31'd0, load_err}, 32'd0);
    repeat (10) @(negedge clk);
    chk("tmo_err", {31'd0, load_err}, 32'd1);
    chk("tmo_bytes", bytes_loaded, 32'd2);
    chk("tmo_wr_cnt", 32'(wr_cnt), 32'd10);
    chk("tmo_hold", {31'd0, cpu_hold}, 32'd1);
    chk("tmo_mem1", {24'd0, mem_model[1]}, 32'h0000_00BB);

    // Reload with gaps and ignored start pulses
    pulse_start();
    chk("reload_clears_err", {31'd0, load_err}, 32'd0);
    put(8'h05, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(p5[0], 1'b1, 32'd0);
    repeat (3) @(negedge clk);
    put(p5[1], 1'b1, 32'd1);
    @(negedge clk);
    pulse_start();
    chk("midload_start_ready", {31'd0, rx_ready}, 32'd1);
    chk("midload_start_bytes", bytes_loaded, 32'd2);
    repeat (5) @(negedge clk);
    put(p5[2], 1'b1, 32'd2);
    put(p5[3], 1'b1, 32'd3);
    repeat (9) @(negedge clk);
    start = 1'b1;
    put(p5[4], 1'b1, 32'd4);
    start = 1'b0;
    @(negedge clk);
    chk("gap_done", {31'd0, load_done}, 32'd1);
    chk("gap_hold", {31'd0, cpu_hold}, 32'd0);
    chk("gap_bytes", bytes_loaded, 32'd5);
    chk("gap_wr_cnt", 32'(wr_cnt), 32'd15);
    for (int i = 0; i < 5; i++) chk("mem_gap", {24'd0, mem_model[i]}, {24'd0, p5[i]});

    // Reset in the middle of a load
    pulse_start();
    put(8'h08, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'h00, 1'b0, 32'd0);
    put(8'hD0, 1'b1, 32'd0);
    put(8'hD1, 1'b1, 32'd1);
    put(8'hD2, 1'b1, 32'd2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_hold", {31'd0, cpu_hold}, 32'd0);
    chk("mrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("mrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mrst_bytes", bytes_loaded, 32'd0);
    chk("mrst_addr_fetch", mem_addr, 32'd4);
    chk("mrst_mem2_kept", {24'd0, mem_model[2]}, 32'h0000_00D2);
    chk("mrst_mem3_kept", {24'd0, mem_model[3]}, 32'h0000_00C4);
    chk("mrst_wr_cnt", 32'(wr_cnt), 32'd18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot/program-load controller for the byte-addressed instruction memory (little-endian, 4 bytes per instruction, combinational read).
- Accepts a length-prefixed byte stream from a UART-style source and writes it into instruction memory.
- Holds the pipeline during a load and owns the instruction-memory address port while loading; fetch owns it otherwise.

Parameters:
- MEM_BYTES, 65536, instruction-memory size in bytes.
- BASE_ADDR, 0, byte address of the first payload byte.
- TIMEOUT_CYC, 1000000, max idle cycles between accepted bytes during a load before error.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- rx_valid  input  1  source byte valid.
- rx_data  input  8  source byte.
- rx_ready  output  1  loader can accept a byte.
- fetch_pc  input  32  fetch-stage PC.
- mem_addr  output  32  instruction-memory byte address (loader address while loading, else fetch_pc).
- mem_we  output  1  byte write strobe.
- mem_wdata  output  8  byte write data.
- cpu_hold  output  1  stall and flush request to the pipeline.
- load_done  output  1  last load completed successfully.
- load_err  output  1  last load aborted.
- bytes_loaded  output  32  payload bytes written in the current or last load.

Behaviour:
- States: IDLE, LEN, LOAD, DRAIN, DONE, ERROR.
- Reset values: state=IDLE; rx_ready=0, mem_we=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, bytes_loaded=0.
- A byte is accepted in a cycle where rx_valid && rx_ready.
- rx_ready: 1 only in LEN and LOAD; forced 0 in every other state.
- IDLE/DONE/ERROR + start -> LEN:
  - clear len, byte index, bytes_loaded, load_done, load_err and timeout counter.
  - cpu_hold=1 from the next cycle.
- LEN: accept 4 bytes, little-endian, into a 32-bit len.
  - After the 4th byte, next state is one of:
    - len==0 -> DONE;
    - len > MEM_BYTES-BASE_ADDR -> ERROR;
    - else -> LOAD.
- LOAD: each accepted byte is registered; in the following cycle:
  - mem_we=1, mem_addr=BASE_ADDR+index, mem_wdata=byte;
  - index and bytes_loaded increment.
  - Write latency: 1 cycle after acceptance.
  - Back-to-back acceptance is allowed, giving one write per cycle.
  - The byte that makes index==len-1 moves the FSM to DRAIN.
- DRAIN: performs the final write, then -> DONE.
- DONE: load_done=1 and cpu_hold=0, from the cycle after the final mem_we.
- ERROR: load_err=1, cpu_hold stays 1, no further writes.
- mem_addr mux:
  - loader address in LEN/LOAD/DRAIN/ERROR;
  - fetch_pc in IDLE/DONE, passed through combinationally.
- Timeout: in LEN/LOAD the counter increments each cycle with no accepted byte and clears on acceptance. Reaching TIMEOUT_CYC -> ERROR; a pending write still completes first.
- start while in LEN/LOAD/DRAIN: ignored.
- start simultaneous with the last byte: ignored.
- Bytes offered outside LEN/LOAD are not accepted; rx_ready=0.
- Reset mid-load: immediate return to IDLE next edge, all outputs reset. Memory contents already written are left as they are.
- Arithmetic: index and len are 32-bit unsigned. The address add cannot overflow because of the length check.

Decomposition:
- Shared package: FSM state encoding, UART byte width (8), and the constant MEM_BYTES shared with the instruction memory.
- Natural sub-module: imem_port_mux, the combinational address/write arbitration between loader and fetch. The FSM, counters and timeout stay in the top.

Test Plan:
- reset, start, stream 08 00 00 00 then 13 00 00 00 93 00 10 00 back-to-back -> 8 mem_we pulses at addrs 0..7, 1 cycle after each accept; cpu_hold high from start+1 until the cycle after the last write; load_done=1, bytes_loaded=8; a subsequent fetch_pc=4 gives mem_addr=4.
- Length 00 00 00 00 -> no mem_we, DONE right after 4th byte, cpu_hold low, load_done=1.
- Length 01 00 01 00 (65537) with MEM_BYTES=65536 -> ERROR after 4th byte, rx_ready=0, load_err=1, cpu_hold stays 1.
- TIMEOUT_CYC=16; len=4, send 2 bytes then stall 16 cycles -> load_err=1, exactly 2 writes, bytes_loaded=2; a new start then clears load_err and reloads.
- Random rx_valid gaps (<16 cycles) with a start pulse mid-LOAD -> start ignored, all bytes written in order at the correct addresses.
- reset asserted during LOAD after 3 payload bytes -> next cycle IDLE, cpu_hold=0, rx_ready=0, mem_we=0, bytes_loaded=0.
